// File: rtl/codecracker_onchip_ram_dp_pkg.sv
// Shared types and helpers for the CodeCracker dual-port on-chip RAM.
//   mem_state_e  : controller state (zero-fill in progress / serving traffic)
//   lane_count() : number of byte lanes in a data word
//   read_latency(): enabled cycles from read accept to readdatavalid
package codecracker_mem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int read_latency(input int output_reg);
    return (output_reg != 0) ? 2 : 1;
  endfunction

endpackage

// File: rtl/codecracker_onchip_ram_dp_if.sv
// Avalon-MM slave bundle for one RAM port.
//   address/chipselect/read/write/byteenable/writedata : master -> slave
//   readdata/readdatavalid/waitrequest                 : slave -> master
//
// Handshake: a request is taken on a rising clock edge where
// chipselect & (read | write) & ~waitrequest. A master seeing waitrequest=1
// keeps its request on the bus. read together with write is a write only.
// Each accepted read produces exactly one readdatavalid pulse, in order;
// readdata holds its previous value whenever readdatavalid is 0.
interface codecracker_onchip_ram_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/codecracker_ram_bank.sv
// Inferred true-dual-port RAM with per-byte write enables.
//   clk          : clock
//   en           : clock enable; 0 freezes both q registers and the array
//   a_* / b_*    : address, byte write enables, write data, read data
// Reads return the contents before any write on the same edge; callers that
// need write-through behaviour across ports handle it outside. When both
// ports write the same lane of the same word, port A wins.
module codecracker_ram_bank
  import codecracker_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [ADDR_W-1:0]             a_addr,
  input  logic [lane_count(DATA_W)-1:0] a_we,
  input  logic [DATA_W-1:0]             a_wd,
  output logic [DATA_W-1:0]             a_q,
  input  logic [ADDR_W-1:0]             b_addr,
  input  logic [lane_count(DATA_W)-1:0] b_we,
  input  logic [DATA_W-1:0]             b_wd,
  output logic [DATA_W-1:0]             b_q
);
  localparam int NB = lane_count(DATA_W);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      a_q <= mem[a_addr];
      b_q <= mem[b_addr];
      // Port B lanes are written first so port A overrides on a collision.
      for (int l = 0; l < NB; l++) begin
        if (b_we[l]) mem[b_addr][8*l +: 8] <= b_wd[8*l +: 8];
      end
      for (int l = 0; l < NB; l++) begin
        if (a_we[l]) mem[a_addr][8*l +: 8] <= a_wd[8*l +: 8];
      end
    end
  end
endmodule

// File: rtl/codecracker_onchip_ram_dp.sv
// CodeCracker true-dual-port on-chip RAM with two Avalon-MM slaves.
//   clk, reset (async, active high), clken (global enable), reset_req (stall)
//   s1, s2     : slave ports (s1 CPU, s2 DMA/accelerator)
//   init_done  : 1 once the power-up zero-fill has finished
//   dbg_state  : current controller state (mem_state_e encoding)
// After reset the array is zero-filled one word per enabled cycle through the
// port-A path while both ports stall. Reads see same-cycle writes from the
// other port via a per-lane bypass captured at accept time.
module codecracker_onchip_ram_dp
  import codecracker_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 14,
  parameter int OUTPUT_REG = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clken,
  input  logic                      reset_req,
  codecracker_onchip_ram_dp_if.slave s1,
  codecracker_onchip_ram_dp_if.slave s2,
  output logic                      init_done,
  output logic [0:0]                dbg_state
);
  localparam int NB  = lane_count(DATA_W);
  localparam int LAT = read_latency(OUTPUT_REG);

  localparam logic [0:0] S_CLEAR = 1'(ST_CLEAR);
  localparam logic [0:0] S_READY = 1'(ST_READY);

  // Port signals gathered into arrays so both ports share one code path.
  logic [ADDR_W-1:0] p_addr [2];
  logic [1:0]        p_cs, p_rd, p_wr;
  logic [NB-1:0]     p_be [2];
  logic [DATA_W-1:0] p_wd [2];

  assign p_addr[0] = s1.address;    assign p_addr[1] = s2.address;
  assign p_cs[0]   = s1.chipselect; assign p_cs[1]   = s2.chipselect;
  assign p_rd[0]   = s1.read;       assign p_rd[1]   = s2.read;
  assign p_wr[0]   = s1.write;      assign p_wr[1]   = s2.write;
  assign p_be[0]   = s1.byteenable; assign p_be[1]   = s2.byteenable;
  assign p_wd[0]   = s1.writedata;  assign p_wd[1]   = s2.writedata;

  // ---------------- controller FSM ----------------
  logic [0:0]        state_q;
  logic [ADDR_W-1:0] clr_ctr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= (INIT_CLEAR != 0) ? S_CLEAR : S_READY;
      clr_ctr <= '0;
    end else if (clken && state_q == S_CLEAR) begin
      clr_ctr <= clr_ctr + ADDR_W'(1);
      if (clr_ctr == {ADDR_W{1'b1}}) state_q <= S_READY;
    end
  end

  assign init_done = (state_q == S_READY);
  assign dbg_state = state_q;

  // ---------------- accept logic ----------------
  logic       stall;
  logic       clearing;
  logic       same_addr;
  logic [1:0] acc_rd, acc_wr;

  assign stall     = (state_q != S_READY) | reset_req | ~clken;
  assign clearing  = (state_q == S_CLEAR);
  assign same_addr = (p_addr[0] == p_addr[1]);

  assign s1.waitrequest = stall;
  assign s2.waitrequest = stall;

  always_comb begin
    acc_rd = '0;
    acc_wr = '0;
    for (int p = 0; p < 2; p++) begin
      acc_wr[p] = p_cs[p] & p_wr[p] & ~stall;
      acc_rd[p] = p_cs[p] & p_rd[p] & ~p_wr[p] & ~stall;
    end
  end

  // ---------------- RAM bank ----------------
  logic [ADDR_W-1:0] bank_a_addr;
  logic [NB-1:0]     bank_a_we, bank_b_we;
  logic [DATA_W-1:0] bank_a_wd;
  logic [DATA_W-1:0] bank_q [2];

  assign bank_a_addr = clearing ? clr_ctr : p_addr[0];
  assign bank_a_we   = clearing ? {NB{1'b1}} : (acc_wr[0] ? p_be[0] : '0);
  assign bank_a_wd   = clearing ? '0 : p_wd[0];
  // s2 drops the lanes s1 also writes on a same-address collision.
  assign bank_b_we   = acc_wr[1] ?
                       (p_be[1] & ~((acc_wr[0] & same_addr) ? p_be[0] : '0)) : '0;

  codecracker_ram_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk    (clk),
    .en     (clken),
    .a_addr (bank_a_addr),
    .a_we   (bank_a_we),
    .a_wd   (bank_a_wd),
    .a_q    (bank_q[0]),
    .b_addr (p_addr[1]),
    .b_we   (bank_b_we),
    .b_wd   (p_wd[1]),
    .b_q    (bank_q[1])
  );

  // ---------------- cross-port bypass ----------------
  // A read only ever collides with the other port's write (a same-port
  // read+write is treated as a write), so one lane mask per port suffices.
  logic [NB-1:0]     byp_be [2];
  logic [DATA_W-1:0] byp_wd [2];

  assign byp_be[0] = (acc_rd[0] & acc_wr[1] & same_addr) ? p_be[1] : '0;
  assign byp_wd[0] = p_wd[1];
  assign byp_be[1] = (acc_rd[1] & acc_wr[0] & same_addr) ? p_be[0] : '0;
  assign byp_wd[1] = p_wd[0];

  // ---------------- read pipelines ----------------
  logic [1:0]        rvalid;
  logic [DATA_W-1:0] rdata [2];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              v1_q;
    logic [NB-1:0]     bm_q;
    logic [DATA_W-1:0] bd_q;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] last_data;
    logic [DATA_W-1:0] hold_q;
    logic              vlast;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v1_q <= 1'b0;
        bm_q <= '0;
        bd_q <= '0;
      end else if (clken) begin
        v1_q <= acc_rd[p];
        bm_q <= byp_be[p];
        bd_q <= byp_wd[p];
      end
    end

    always_comb begin
      merged = bank_q[p];
      for (int l = 0; l < NB; l++) begin
        if (bm_q[l]) merged[8*l +: 8] = bd_q[8*l +: 8];
      end
    end

    if (LAT == 2) begin : g_oreg
      logic              v2_q;
      logic [DATA_W-1:0] d2_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v2_q <= 1'b0;
          d2_q <= '0;
        end else if (clken) begin
          v2_q <= v1_q;
          if (v1_q) d2_q <= merged;
        end
      end
      assign vlast     = v2_q;
      assign last_data = d2_q;
    end else begin : g_noreg
      assign vlast     = v1_q;
      assign last_data = merged;
    end

    // A result due while clken=0 waits for the next enabled cycle, so
    // readdatavalid is qualified with clken and the data is shown only then.
    assign rvalid[p] = vlast & clken;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)          hold_q <= '0;
      else if (rvalid[p]) hold_q <= last_data;
    end

    assign rdata[p] = rvalid[p] ? last_data : hold_q;
  end

  assign s1.readdata      = rdata[0];
  assign s1.readdatavalid = rvalid[0];
  assign s2.readdata      = rdata[1];
  assign s2.readdatavalid = rvalid[1];
endmodule

// File: tb/tb_codecracker_onchip_ram_dp.sv
module tb_codecracker_onchip_ram_dp;
  import codecracker_mem_pkg::*;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 4;
  localparam int OUTPUT_REG = 0;
  localparam int INIT_CLEAR = 1;
  localparam int NB         = DATA_W / 8;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int LAT        = (OUTPUT_REG != 0) ? 2 : 1;

  // ---------------- clock / reset ----------------
  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       clken     = 1'b1;
  logic       reset_req = 1'b0;
  logic       init_done;
  logic [0:0] dbg_state;

  always #5 clk = ~clk;

  codecracker_onchip_ram_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s1 ();
  codecracker_onchip_ram_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s2 ();

  codecracker_onchip_ram_dp #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .OUTPUT_REG (OUTPUT_REG),
    .INIT_CLEAR (INIT_CLEAR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .reset_req (reset_req),
    .s1        (s1),
    .s2        (s2),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // ---------------- reference model / scoreboard ----------------
  // Memory as an array; each accepted read is queued with the enabled-cycle
  // count at which its result is due. Reads see the word after all of this
  // cycle's writes (s2 lanes first, then s1 lanes on top).
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                clear_left = DEPTH;
  int                en_cnt = 0;
  logic [DATA_W-1:0] exp_q1 [$];
  logic [DATA_W-1:0] exp_q2 [$];
  int                due_q1 [$];
  int                due_q2 [$];
  logic [DATA_W-1:0] last1 = '0;
  logic [DATA_W-1:0] last2 = '0;

  always @(negedge clk) begin : monitor
    logic ew, ev1, ev2, a1w, a1r, a2w, a2r;
    if (reset) begin
      clear_left = (INIT_CLEAR != 0) ? DEPTH : 0;
      exp_q1.delete(); exp_q2.delete(); due_q1.delete(); due_q2.delete();
      last1 = '0; last2 = '0;
      cmp_cnt++;
      if (s1.waitrequest !== 1'b1 || s2.waitrequest !== 1'b1 ||
          s1.readdatavalid !== 1'b0 || s2.readdatavalid !== 1'b0 ||
          s1.readdata !== '0 || s2.readdata !== '0 || init_done !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_outputs: wr=%b%b rv=%b%b rd1=%h rd2=%h done=%b, required wr=11 rv=00 rd=0 done=0",
                 s1.waitrequest, s2.waitrequest, s1.readdatavalid, s2.readdatavalid,
                 s1.readdata, s2.readdata, init_done);
      end
    end else begin
      ew = (clear_left != 0) || reset_req || !clken;
      cmp_cnt++;
      if (s1.waitrequest !== ew || s2.waitrequest !== ew) begin
        err_cnt++;
        $display("FAIL waitrequest @%0t: got %b/%b required %b", $time, s1.waitrequest, s2.waitrequest, ew);
      end
      cmp_cnt++;
      if (init_done !== (clear_left == 0)) begin
        err_cnt++;
        $display("FAIL init_done @%0t: got %b required %b", $time, init_done, clear_left == 0);
      end
      ev1 = clken && due_q1.size() > 0 && due_q1[0] == en_cnt;
      ev2 = clken && due_q2.size() > 0 && due_q2[0] == en_cnt;
      cmp_cnt++;
      if (s1.readdatavalid !== ev1) begin
        err_cnt++;
        $display("FAIL s1_valid @%0t: got %b required %b", $time, s1.readdatavalid, ev1);
      end
      if (ev1) begin last1 = exp_q1.pop_front(); void'(due_q1.pop_front()); end
      cmp_cnt++;
      if (s1.readdata !== last1) begin
        err_cnt++;
        $display("FAIL s1_data @%0t: got %h required %h", $time, s1.readdata, last1);
      end
      cmp_cnt++;
      if (s2.readdatavalid !== ev2) begin
        err_cnt++;
        $display("FAIL s2_valid @%0t: got %b required %b", $time, s2.readdatavalid, ev2);
      end
      if (ev2) begin last2 = exp_q2.pop_front(); void'(due_q2.pop_front()); end
      cmp_cnt++;
      if (s2.readdata !== last2) begin
        err_cnt++;
        $display("FAIL s2_data @%0t: got %h required %h", $time, s2.readdata, last2);
      end
      // advance the model across the coming edge
      if (clken) begin
        en_cnt++;
        if (clear_left > 0) begin
          clear_left--;
          if (clear_left == 0) for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (!reset_req) begin
          a1w = s1.chipselect && s1.write;
          a1r = s1.chipselect && s1.read && !s1.write;
          a2w = s2.chipselect && s2.write;
          a2r = s2.chipselect && s2.read && !s2.write;
          for (int l = 0; l < NB; l++)
            if (a2w && s2.byteenable[l]) m_mem[s2.address][8*l +: 8] = s2.writedata[8*l +: 8];
          for (int l = 0; l < NB; l++)
            if (a1w && s1.byteenable[l]) m_mem[s1.address][8*l +: 8] = s1.writedata[8*l +: 8];
          if (a1r) begin exp_q1.push_back(m_mem[s1.address]); due_q1.push_back(en_cnt + LAT - 1); end
          if (a2r) begin exp_q2.push_back(m_mem[s2.address]); due_q2.push_back(en_cnt + LAT - 1); end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1.chipselect = 1'b0; s1.read = 1'b0; s1.write = 1'b0;
    s1.address = '0; s1.byteenable = '0; s1.writedata = '0;
    s2.chipselect = 1'b0; s2.read = 1'b0; s2.write = 1'b0;
    s2.address = '0; s2.byteenable = '0; s2.writedata = '0;
  endtask

  task automatic s1_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    s1.chipselect = 1'b1; s1.write = 1'b1; s1.read = 1'b0;
    s1.address = a; s1.writedata = d; s1.byteenable = be;
  endtask

  task automatic s2_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    s2.chipselect = 1'b1; s2.write = 1'b1; s2.read = 1'b0;
    s2.address = a; s2.writedata = d; s2.byteenable = be;
  endtask

  task automatic s1_rd(input logic [ADDR_W-1:0] a);
    s1.chipselect = 1'b1; s1.write = 1'b0; s1.read = 1'b1; s1.address = a;
  endtask

  task automatic s2_rd(input logic [ADDR_W-1:0] a);
    s2.chipselect = 1'b1; s2.write = 1'b0; s2.read = 1'b1; s2.address = a;
  endtask

  // Counts stall cycles until init_done; also counts any readdatavalid seen.
  task automatic count_clear(output int n, output int stray, output logic done);
    n = 0; stray = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (s1.readdatavalid === 1'b1 || s2.readdatavalid === 1'b1) stray++;
      if (s1.waitrequest === 1'b1) begin n++; next(); end
      else done = 1'b1;
    end
    next();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n, stray;
    logic done;
    reset = 1'b1; idle();
    repeat (3) next();
    @(negedge clk);
    cmp_cnt++;
    if (s1.waitrequest !== 1'b1 || init_done !== 1'b0 || dbg_state !== 1'(ST_CLEAR)) begin
      err_cnt++;
      $display("FAIL reset_state: wr=%b done=%b st=%b, required 1 0 %b", s1.waitrequest, init_done, dbg_state, 1'(ST_CLEAR));
    end
    next();
    reset = 1'b0;
    count_clear(n, stray, done);
    cmp_cnt++;
    if (!done || n != DEPTH || init_done !== 1'b1 || dbg_state !== 1'(ST_READY)) begin
      err_cnt++;
      $display("FAIL clear_length: stall cycles %0d done=%b st=%b, required %0d 1 %b", n, init_done, dbg_state, DEPTH, 1'(ST_READY));
    end
    for (int i = 0; i < DEPTH + LAT; i++) begin
      if (i < DEPTH) s1_rd(ADDR_W'(i)); else idle();
      @(negedge clk);
      if (i >= LAT) begin
        cmp_cnt++;
        if (s1.readdatavalid !== 1'b1 || s1.readdata !== '0) begin
          err_cnt++;
          $display("FAIL zero_fill[%0d]: valid=%b data=%h, required 1 00000000", i - LAT, s1.readdatavalid, s1.readdata);
        end
      end
      next();
    end
    idle();
  endtask

  task automatic test_byte_lanes();
    int  lat;
    logic got;
    s1_wr(4'd5, 32'h11223344, 4'hF); next();
    s1_wr(4'd5, 32'hAABBCCDD, 4'h2); next();
    s1_rd(4'd5); next();
    idle();
    lat = 1; got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (s1.readdatavalid === 1'b1) got = 1'b1;
      else begin next(); lat++; end
    end
    cmp_cnt++;
    if (!got || lat != LAT || s1.readdata !== 32'h1122CC44) begin
      err_cnt++;
      $display("FAIL byte_lanes: got=%b lat=%0d data=%h, required 1 %0d 1122cc44", got, lat, s1.readdata, LAT);
    end
    next();
  endtask

  task automatic test_dual_write();
    s1_wr(4'd7, 32'hAAAAAAAA, 4'h3);
    s2_wr(4'd7, 32'h55555555, 4'hE);
    next();
    idle(); s1_rd(4'd7); next();
    idle();
    repeat (LAT - 1) next();
    @(negedge clk);
    cmp_cnt++;
    if (s1.readdatavalid !== 1'b1 || s1.readdata !== 32'h5555AAAA) begin
      err_cnt++;
      $display("FAIL dual_write: valid=%b data=%h, required 1 5555aaaa", s1.readdatavalid, s1.readdata);
    end
    next();
  endtask

  task automatic test_bypass();
    s1_wr(4'd9, 32'hDEADBEEF, 4'hF);
    s2_rd(4'd9);
    next();
    idle();
    repeat (LAT - 1) next();
    @(negedge clk);
    cmp_cnt++;
    if (s2.readdatavalid !== 1'b1 || s2.readdata !== 32'hDEADBEEF) begin
      err_cnt++;
      $display("FAIL bypass_s1_to_s2: valid=%b data=%h, required 1 deadbeef", s2.readdatavalid, s2.readdata);
    end
    next();
    s2_wr(4'd9, 32'h01020304, 4'h5);
    s1_rd(4'd9);
    next();
    idle();
    repeat (LAT - 1) next();
    @(negedge clk);
    cmp_cnt++;
    if (s1.readdatavalid !== 1'b1 || s1.readdata !== 32'hDE02BE04) begin
      err_cnt++;
      $display("FAIL bypass_s2_to_s1: valid=%b data=%h, required 1 de02be04", s1.readdatavalid, s1.readdata);
    end
    next();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] pat [4];
    logic [DATA_W-1:0] got_d [$];
    for (int i = 0; i < 4; i++) begin
      pat[i] = $urandom;
      s1_wr(ADDR_W'(i), pat[i], 4'hF);
      next();
    end
    idle();
    for (int c = 0; c < 10; c++) begin
      case (c)
        0:       s2_rd(4'd0);
        1:       s2_rd(4'd1);
        2, 3:    begin s2_rd(4'd2); clken = 1'b0; end
        4:       begin clken = 1'b1; s2_rd(4'd2); end
        5:       s2_rd(4'd3);
        default: idle();
      endcase
      @(negedge clk);
      if (s2.readdatavalid === 1'b1) got_d.push_back(s2.readdata);
      next();
    end
    cmp_cnt++;
    if (got_d.size() != 4) begin
      err_cnt++;
      $display("FAIL clken_burst_count: got %0d valids, required 4", got_d.size());
    end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      cmp_cnt++;
      if (got_d[i] !== pat[i]) begin
        err_cnt++;
        $display("FAIL clken_burst_data[%0d]: got %h required %h", i, got_d[i], pat[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, stray;
    logic done;
    reset = 1'b1; next();
    reset = 1'b0;
    repeat (8) next();
    reset = 1'b1; next();
    reset = 1'b0;
    count_clear(n, stray, done);
    cmp_cnt++;
    if (!done || n != DEPTH) begin
      err_cnt++;
      $display("FAIL reset_mid_clear: stall cycles %0d, required %0d", n, DEPTH);
    end
    s1_rd(4'd3); s2_rd(4'd4); next();
    reset = 1'b1; idle();
    @(negedge clk);
    cmp_cnt++;
    if (s1.readdatavalid !== 1'b0 || s2.readdatavalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_flush: valid=%b%b, required 00", s1.readdatavalid, s2.readdatavalid);
    end
    next();
    reset = 1'b0;
    count_clear(n, stray, done);
    cmp_cnt++;
    if (!done || n != DEPTH || stray != 0) begin
      err_cnt++;
      $display("FAIL reset_mid_read: stall %0d stray %0d, required %0d 0", n, stray, DEPTH);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 240; c++) begin
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 9) == 0);
      s1.chipselect = ($urandom_range(0, 3) != 0);
      s1.read       = ($urandom_range(0, 1) != 0);
      s1.write      = ($urandom_range(0, 2) == 0);
      s1.address    = ADDR_W'($urandom_range(0, 3));
      s1.byteenable = NB'($urandom_range(0, 15));
      s1.writedata  = $urandom;
      s2.chipselect = ($urandom_range(0, 3) != 0);
      s2.read       = ($urandom_range(0, 1) != 0);
      s2.write      = ($urandom_range(0, 2) == 0);
      s2.address    = ADDR_W'($urandom_range(0, 3));
      s2.byteenable = NB'($urandom_range(0, 15));
      s2.writedata  = $urandom;
      next();
    end
    idle(); clken = 1'b1; reset_req = 1'b0;
    repeat (LAT + 3) next();
    cmp_cnt++;
    if (exp_q1.size() != 0 || exp_q2.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: pending %0d/%0d reads never returned, required 0/0", exp_q1.size(), exp_q2.size());
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_byte_lanes();
    test_dual_write();
    test_bypass();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
